uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_parity.sv | 22 ++
 rtl/uart_transmitter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling, frame-length limits and parity encoding.
// Used by both the transmitter and the receiver side of the UART.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int MIN_LEN    = 5;
    localparam int MAX_LEN    = 9;
    localparam int WORD_W     = MAX_LEN;
    localparam int LEN_W      = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_t;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_type_t;

    // Out-of-range lengths are folded into the legal window rather than rejected.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] result;
        result = len;
        if (len < LEN_W'(MIN_LEN)) begin
            result = LEN_W'(MIN_LEN);
        end else if (len > LEN_W'(MAX_LEN)) begin
            result = LEN_W'(MAX_LEN);
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_parity.sv
// Combinational parity over the low i_len bits of a 9-bit word.
// Result makes the total number of ones even (PARITY_EVEN) or odd (PARITY_ODD).
module uart_parity
    import uart_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_parity_type,
    output logic              o_parity_bit
);

    logic [WORD_W-1:0] w_masked;

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_mask
            assign w_masked[gi] = i_word[gi] & (LEN_W'(gi) < i_len);
        end
    endgenerate

    assign o_parity_bit = (^w_masked) ^ (i_parity_type == PARITY_ODD);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter clocked at 16x baud: start bit, 5..9 data bits LSB first,
// optional parity, one or two stop bits, with a ready/valid request handshake.
module uart_transmitter
    import uart_pkg::*;
(
    input  logic              clk_16bd,
    input  logic              rst,
    input  logic [WORD_W-1:0] data,
    input  logic              data_valid,
    output logic              ready,
    input  logic              parity,
    input  logic              parity_type,
    input  logic              stop_bits,
    input  logic [LEN_W-1:0]  frame_length,
    output logic              Tx,
    output logic              tx_done
);

    uart_state_t       r_state, w_state_next;
    logic [TICK_W-1:0] r_tick, w_tick_next;
    logic [LEN_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic [WORD_W-1:0] r_shift, w_shift_next;
    logic [LEN_W-1:0]  r_len, w_len_next;
    logic              r_par_en, w_par_en_next;
    logic              r_par_bit, w_par_bit_next;
    logic              r_stop2, w_stop2_next;
    logic              r_tx, w_tx_next;

    logic              w_bit_end;
    logic              w_last_bit;
    logic              w_accept;
    logic              w_parity_bit;
    logic [LEN_W-1:0]  w_len_clamped;

    assign w_len_clamped = clamp_len(frame_length);

    // Parity is taken from the incoming word at acceptance, before the shift register consumes it.
    uart_parity u_parity (
        .i_word        (data),
        .i_len         (w_len_clamped),
        .i_parity_type (parity_type),
        .o_parity_bit  (w_parity_bit)
    );

    assign w_bit_end  = (r_tick == TICK_W'(OVERSAMPLE - 1));
    assign w_last_bit = w_bit_end &&
                        ((r_state == STOP2) || ((r_state == STOP1) && !r_stop2));
    assign ready      = (r_state == IDLE) || w_last_bit;
    assign tx_done    = w_last_bit;
    assign w_accept   = ready && data_valid;
    assign Tx         = r_tx;

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_len     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_tick    <= w_tick_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_len     <= w_len_next;
            r_par_en  <= w_par_en_next;
            r_par_bit <= w_par_bit_next;
            r_stop2   <= w_stop2_next;
            r_tx      <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_tick_next    = r_tick + TICK_W'(1);
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_len_next     = r_len;
        w_par_en_next  = r_par_en;
        w_par_bit_next = r_par_bit;
        w_stop2_next   = r_stop2;
        w_tx_next      = r_tx;

        // r_tx is loaded one cycle ahead so each new bit appears right after the bit boundary.
        case (r_state)
            IDLE: begin
                w_tick_next = '0;
                w_tx_next   = 1'b1;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = LEN_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt != r_len) begin
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = r_bit_cnt + LEN_W'(1);
                    end else if (r_par_en) begin
                        w_state_next = PARITY;
                        w_tx_next    = r_par_bit;
                    end else begin
                        w_state_next = STOP1;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP1;
                    w_tx_next    = 1'b1;
                end
            end
            STOP1: begin
                if (w_bit_end && r_stop2) begin
                    w_state_next = STOP2;
                    w_tx_next    = 1'b1;
                end
            end
            STOP2: begin
                w_tx_next = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
                w_tick_next  = '0;
                w_tx_next    = 1'b1;
            end
        endcase

        if (w_last_bit) begin
            w_state_next   = IDLE;
            w_tick_next    = '0;
            w_bit_cnt_next = '0;
            w_tx_next      = 1'b1;
        end

        // Acceptance overrides the return to IDLE, giving gap-free back-to-back frames.
        if (w_accept) begin
            w_state_next   = START;
            w_tick_next    = '0;
            w_bit_cnt_next = '0;
            w_tx_next      = 1'b0;
            w_shift_next   = data;
            w_len_next     = w_len_clamped;
            w_par_en_next  = parity;
            w_par_bit_next = w_parity_bit;
            w_stop2_next   = stop_bits;
        end
    end

endmodule
